// File: rtl/queens_job_scheduler.sv
// -----------------------------------------------------------------------------
// queens_job_scheduler
//
// Sequences one N-Queens run across NUM_ENG solver engines. The board is split
// into n sub-jobs, one per first-row queen column 0..n-1. Each job is handed to
// the lowest-numbered free engine, at most one launch per cycle. Every engine
// returns a CNT_W-bit solution count with a done pulse; all counts that arrive
// in a cycle are summed into a saturating running total.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      single-cycle run request, honoured only while idle
//   n          board size, captured when start is accepted
//   eng_start  one-hot launch pulse, one engine per cycle at most
//   eng_col    per-engine first-row column (N_W bits per engine), valid from
//              that engine's eng_start until its eng_done
//   eng_n      captured board size, held for the whole run
//   eng_done   per-engine completion pulse
//   eng_count  per-engine solution count (CNT_W bits per engine), valid with
//              the matching eng_done bit
//   busy       high from start acceptance through the done cycle
//   done       single-cycle run-complete pulse
//   total      accumulated solution count
//   ovf        sticky saturation flag for the current run
//   err        last run was rejected because n was illegal
//   state_dbg  current FSM state (IDLE=0, RUN=1, DRAIN=2, FIN=3)
//
// Handshake: eng_start[i] is a single-cycle pulse with eng_col slice i valid in
// that same cycle; the engine owns the job until it raises eng_done[i] for one
// cycle with eng_count slice i valid in that cycle. A done pulse from an engine
// that holds no job is ignored.
// -----------------------------------------------------------------------------
module queens_job_scheduler #(
  parameter int NUM_ENG = 8,
  parameter int CNT_W   = 24,
  parameter int N_W     = 5,
  parameter int MAX_N   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [N_W-1:0]           n,
  output logic [NUM_ENG-1:0]       eng_start,
  output logic [NUM_ENG*N_W-1:0]   eng_col,
  output logic [N_W-1:0]           eng_n,
  input  logic [NUM_ENG-1:0]       eng_done,
  input  logic [NUM_ENG*CNT_W-1:0] eng_count,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         total,
  output logic                     ovf,
  output logic                     err,
  output logic [1:0]               state_dbg
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  // Four guard bits cover up to 15 simultaneous counts on top of the total.
  localparam int SUM_W = CNT_W + 4;

  localparam logic [N_W-1:0]     MAX_N_V = N_W'(MAX_N);
  localparam logic [N_W-1:0]     ONE_COL = N_W'(1);
  localparam logic [NUM_ENG-1:0] ONE_ENG = NUM_ENG'(1);
  localparam logic [SUM_W-1:0]   SAT_V   = {4'b0000, {CNT_W{1'b1}}};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]             state_q;
  logic [N_W-1:0]         n_q;
  logic [N_W-1:0]         next_col_q;
  logic [NUM_ENG-1:0]     out_q;      // engines currently holding a job
  logic [NUM_ENG*N_W-1:0] col_q;      // column last issued to each engine
  logic [CNT_W-1:0]       total_q;
  logic                   ovf_q;
  logic                   err_q;

  // ---------------------------------------------------------------------------
  // Dispatch and collection
  // ---------------------------------------------------------------------------
  logic [NUM_ENG-1:0] free_v;
  logic [NUM_ENG-1:0] lowest_free;
  logic [NUM_ENG-1:0] disp_oh;
  logic [NUM_ENG-1:0] collect;
  logic [NUM_ENG-1:0] out_after;
  logic               disp_valid;
  logic               last_col;
  logic               n_legal;
  logic [SUM_W-1:0]   sum_v;

  always_comb begin
    // Free engines come from the registered mask only, so an engine released
    // by eng_done this cycle cannot be relaunched before the next cycle.
    free_v      = ~out_q;
    // Two's-complement trick isolates the lowest set bit.
    lowest_free = free_v & (~free_v + ONE_ENG);
    disp_valid  = (state_q == S_RUN) && (next_col_q < n_q) && (|free_v);
    disp_oh     = disp_valid ? lowest_free : '0;
    last_col    = (next_col_q == (n_q - ONE_COL));
    collect     = eng_done & out_q;
    out_after   = (out_q & ~collect) | disp_oh;
    n_legal     = (n != '0) && (n <= MAX_N_V);

    sum_v = {4'b0000, total_q};
    for (int i = 0; i < NUM_ENG; i++) begin
      if (collect[i]) begin
        sum_v = sum_v + {4'b0000, eng_count[i*CNT_W +: CNT_W]};
      end
    end
  end

  // The launched engine sees its new column in the same cycle as eng_start;
  // every other slice shows the column it was last given.
  always_comb begin
    eng_col = col_q;
    for (int i = 0; i < NUM_ENG; i++) begin
      if (disp_oh[i]) begin
        eng_col[i*N_W +: N_W] = next_col_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential update
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      next_col_q <= '0;
      out_q      <= '0;
      col_q      <= '0;
      total_q    <= '0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            total_q    <= '0;
            ovf_q      <= 1'b0;
            out_q      <= '0;
            next_col_q <= '0;
            if (n_legal) begin
              n_q     <= n;
              err_q   <= 1'b0;
              state_q <= S_RUN;
            end else begin
              // Rejected: no engine is launched, done follows next cycle.
              err_q   <= 1'b1;
              state_q <= S_FIN;
            end
          end
        end

        S_RUN, S_DRAIN: begin
          out_q <= out_after;

          if (|collect) begin
            if (sum_v > SAT_V) begin
              total_q <= '1;
              ovf_q   <= 1'b1;
            end else begin
              total_q <= sum_v[CNT_W-1:0];
            end
          end

          if (disp_valid) begin
            next_col_q <= next_col_q + ONE_COL;
            for (int i = 0; i < NUM_ENG; i++) begin
              if (disp_oh[i]) begin
                col_q[i*N_W +: N_W] <= next_col_q;
              end
            end
          end

          if (state_q == S_RUN) begin
            if (disp_valid && last_col) begin
              state_q <= S_DRAIN;
            end
          end else if (out_after == '0) begin
            state_q <= S_FIN;
          end
        end

        S_FIN: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign eng_start = disp_oh;
  assign eng_n     = n_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);
  assign total     = total_q;
  assign ovf       = ovf_q;
  assign err       = err_q;
  assign state_dbg = state_q;

endmodule
